// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns PC/old-PC, runs the imem handshake, holds the IR.
// Optional build macro IFU_ILLEGAL_CHECK_EN adds the illegal_instr flag.
module instr_fetch_unit #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_req,
  input  logic            pc_write,
  input  logic [XLEN-1:0] pc_in,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [31:0]     mem_rdata,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] old_pc,
  output logic [31:0]     instr,
  output logic [6:0]      opcode,
  output logic [2:0]      func3,
  output logic [6:0]      func7,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
`ifdef IFU_ILLEGAL_CHECK_EN
  output logic            illegal_instr,
`endif
  output logic            fetch_busy,
  output logic            fetch_done,
  output logic            fetch_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, old_pc_q;
  logic [31:0]     instr_q;
  logic [CW-1:0]   cnt_q;
  logic            mem_req_q, done_q, err_q;
  logic            start, accept, abort;
  logic [31:0]     load_word;
  logic            unused_pc_lsb;

  assign start  = (state_q == IDLE) && fetch_req;
  assign accept = (state_q == WAIT) && mem_rvalid;
  assign abort  = (state_q == WAIT) && !mem_rvalid
               && (cnt_q == CW'(TIMEOUT - 1));

  assign pc_d = pc_write ? {pc_in[XLEN-1:2], 2'b00} : pc_q;
  assign unused_pc_lsb = ^pc_in[1:0];

`ifdef IFU_ILLEGAL_CHECK_EN
  logic ill_word;
  logic ill_q;
  assign ill_word  = (mem_rdata[1:0] != 2'b11) || (mem_rdata == 32'h0);
  assign load_word = ill_word ? NOP_INSTR : mem_rdata;
  assign illegal_instr = ill_q;

  // Illegal flag tracks every IR update; aborts load a legal NOP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       ill_q <= 1'b0;
    else if (accept) ill_q <= ill_word;
    else if (abort)  ill_q <= 1'b0;
  end
`else
  assign load_word = mem_rdata;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: rvalid wins over timeout on the last WAIT cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fetch_req) state_d = REQ;
      REQ:     if (mem_gnt) state_d = WAIT;
      WAIT:    if (accept || abort) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs derived from the current state.
  always_comb begin
    fetch_busy = (state_q != IDLE);
  end

  // Datapath: PC, request address, IR, timeout counter and flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC[XLEN-1:0];
      old_pc_q  <= RESET_PC[XLEN-1:0];
      addr_q    <= RESET_PC[XLEN-1:0];
      instr_q   <= NOP_INSTR;
      cnt_q     <= '0;
      mem_req_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      mem_req_q <= (state_d == REQ);
      done_q    <= accept || abort;
      if (start) begin
        addr_q   <= {pc_q[XLEN-1:2], 2'b00};
        old_pc_q <= pc_q;
        err_q    <= 1'b0;
      end
      if (state_q == REQ) begin
        cnt_q <= '0;
      end else if (state_q == WAIT && !accept && !abort) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (accept) begin
        instr_q <= load_word;
      end else if (abort) begin
        instr_q <= NOP_INSTR;
        err_q   <= 1'b1;
      end
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = addr_q;
  assign pc         = pc_q;
  assign old_pc     = old_pc_q;
  assign instr      = instr_q;
  assign fetch_done = done_q;
  assign fetch_err  = err_q;
  assign opcode     = instr_q[6:0];
  assign rd         = instr_q[11:7];
  assign func3      = instr_q[14:12];
  assign rs1        = instr_q[19:15];
  assign rs2        = instr_q[24:20];
  assign func7      = instr_q[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: table vectors, corner sequences, random fetches.
// Model predicts completion cycle and results from grant/rvalid delays.
module tb_instr_fetch_unit;

  localparam int          TO  = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req, pc_write;
  logic [31:0] pc_in;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] pc, old_pc, instr;
  logic [6:0]  opcode, func7;
  logic [2:0]  func3;
  logic [4:0]  rd, rs1, rs2;
  logic        fetch_busy, fetch_done, fetch_err;
`ifdef IFU_ILLEGAL_CHECK_EN
  logic        illegal_instr;
`endif

  int tests = 0;
  int fails = 0;
  logic [31:0] mpc;

  instr_fetch_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .pc_write(pc_write), .pc_in(pc_in),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .pc(pc), .old_pc(old_pc), .instr(instr),
    .opcode(opcode), .func3(func3), .func7(func7),
    .rd(rd), .rs1(rs1), .rs2(rs2),
`ifdef IFU_ILLEGAL_CHECK_EN
    .illegal_instr(illegal_instr),
`endif
    .fetch_busy(fetch_busy), .fetch_done(fetch_done),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    int          gdly;
    int          rdly;
    logic        pcw;
    logic [31:0] pcin;
    logic [31:0] e_instr;
    logic [4:0]  e_rd;
    logic [6:0]  e_op;
    logic        e_err;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One fetch started now (IDLE). Edge 0 samples fetch_req; grant is
  // sampled at edge gdly+1, rvalid at edge gdly+rdly+2, so done shows
  // after edge d = gdly+2+min(rdly,TO-1).
  task automatic run_fetch(input logic [31:0] rdata, input int gdly,
                           input int rdly, input bit rnd,
                           input logic pcw0, input logic [31:0] pcin0,
                           input logic [31:0] e_instr, input logic e_err,
                           input logic e_ill);
    logic [31:0] eaddr, prev;
    int d;
    d = 2 + gdly + ((rdly < TO) ? rdly : TO - 1);
    eaddr = mpc;
    prev = instr;
    fetch_req = 1'b1;
    pc_write = pcw0;
    pc_in = pcin0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    for (int i = 0; i <= d + 1; i++) begin
      tick();
      if (pc_write) mpc = {pc_in[31:2], 2'b00};
      chk("busy", 32'(fetch_busy), 32'(i < d));
      chk("done", 32'(fetch_done), 32'(i == d));
      chk("mem_req", 32'(mem_req), 32'(i <= gdly));
      if (i <= gdly) chk("mem_addr", mem_addr, eaddr);
      chk("pc", pc, mpc);
      if (i < d) chk("instr_hold", instr, prev);
      if (i == d) begin
        chk("instr", instr, e_instr);
        chk("err", 32'(fetch_err), 32'(e_err));
        chk("old_pc", old_pc, eaddr);
        chk("opcode", 32'(opcode), 32'(e_instr[6:0]));
        chk("rd", 32'(rd), 32'(e_instr[11:7]));
        chk("func3", 32'(func3), 32'(e_instr[14:12]));
        chk("rs1", 32'(rs1), 32'(e_instr[19:15]));
        chk("rs2", 32'(rs2), 32'(e_instr[24:20]));
        chk("func7", 32'(func7), 32'(e_instr[31:25]));
`ifdef IFU_ILLEGAL_CHECK_EN
        chk("illegal", 32'(illegal_instr), 32'(e_ill));
`else
        if (e_ill) chk("ill_unexpected", 32'(e_ill), 32'(1'b0));
`endif
      end
      if (i > d) chk("instr_keep", instr, e_instr);
      fetch_req = (i <= d - 1)
                && (rnd ? ($urandom_range(0, 3) == 0) : (i == 1));
      pc_write = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      pc_in = $urandom;
      mem_gnt = (i == gdly);
      mem_rvalid = (i == 1 + gdly + rdly) || (i == 0 && gdly >= 1);
      mem_rdata = (i == 0 && gdly >= 1) ? 32'hDEAD_BEEF : rdata;
    end
    fetch_req = 1'b0;
    pc_write = 1'b0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  function automatic logic is_ill(input logic [31:0] w);
`ifdef IFU_ILLEGAL_CHECK_EN
    return (w[1:0] != 2'b11) || (w == 32'h0);
`else
    return 1'b0 && (w == 32'h0);
`endif
  endfunction

  initial begin
    logic [31:0] w, ei;
    int g, r;
    tbl[0] = '{32'h0050_0093, 0, 0, 1'b1, 32'h4,
               32'h0050_0093, 5'd1, 7'h13, 1'b0};
    tbl[1] = '{32'h0020_8133, 2, 5, 1'b0, 32'h0,
               32'h0020_8133, 5'd2, 7'h33, 1'b0};
    tbl[2] = '{32'hFFFF_FFFF, 0, 20, 1'b0, 32'h0,
               NOP, 5'd0, 7'h13, 1'b1};
    tbl[3] = '{32'h4031_5233, 1, 15, 1'b0, 32'h0,
               32'h4031_5233, 5'd4, 7'h33, 1'b0};
    tbl[4] = '{32'hFE01_0113, 3, 0, 1'b1, 32'h0000_1237,
               32'hFE01_0113, 5'd2, 7'h13, 1'b0};

    reset = 1'b1;
    fetch_req = 1'b0;
    pc_write = 1'b0;
    pc_in = '0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    mpc = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    chk("rst_pc", pc, 32'h0);
    chk("rst_old_pc", old_pc, 32'h0);
    chk("rst_instr", instr, NOP);
    chk("rst_opcode", 32'(opcode), 32'h13);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_busy", 32'(fetch_busy), 32'h0);
    chk("rst_done", 32'(fetch_done), 32'h0);
    chk("rst_err", 32'(fetch_err), 32'h0);

    foreach (tbl[k]) begin
      run_fetch(tbl[k].rdata, tbl[k].gdly, tbl[k].rdly, 1'b0,
                tbl[k].pcw, tbl[k].pcin, tbl[k].e_instr,
                tbl[k].e_err, 1'b0);
      chk($sformatf("tbl%0d_rd", k), 32'(rd), 32'(tbl[k].e_rd));
      chk($sformatf("tbl%0d_op", k), 32'(opcode), 32'(tbl[k].e_op));
    end
    chk("tbl_pc_final", pc, 32'h0000_1234);

    // Reset while waiting for rvalid; the late response must be dropped.
    fetch_req = 1'b1;
    mem_gnt = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    mem_gnt = 1'b0;
    tick();
    chk("t5_busy_pre", 32'(fetch_busy), 32'h1);
    reset = 1'b1;
    #1;
    mpc = '0;
    chk("t5_async_busy", 32'(fetch_busy), 32'h0);
    chk("t5_async_req", 32'(mem_req), 32'h0);
    chk("t5_async_pc", pc, 32'h0);
    chk("t5_async_instr", instr, NOP);
    tick();
    reset = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h00A0_0113;
    tick();
    mem_rvalid = 1'b0;
    chk("t5_done", 32'(fetch_done), 32'h0);
    chk("t5_instr", instr, NOP);
    chk("t5_busy", 32'(fetch_busy), 32'h0);
    tick();
    chk("t5_done2", 32'(fetch_done), 32'h0);
    chk("t5_instr2", instr, NOP);

`ifdef IFU_ILLEGAL_CHECK_EN
    run_fetch(32'h0, 0, 0, 1'b0, 1'b0, 32'h0, NOP, 1'b0, 1'b1);
    run_fetch(32'h0050_0092, 1, 2, 1'b0, 1'b0, 32'h0, NOP, 1'b0, 1'b1);
`endif

    for (int n = 0; n < 40; n++) begin
      w = $urandom;
      if ($urandom_range(0, 4) != 0) w[1:0] = 2'b11;
      g = $urandom_range(0, 3);
      r = ($urandom_range(0, 5) == 0) ? $urandom_range(TO, TO + 3)
                                      : $urandom_range(0, TO - 1);
      if (r >= TO) ei = NOP;
      else         ei = is_ill(w) ? NOP : w;
      run_fetch(w, g, r, 1'b1, 1'($urandom_range(0, 1)), $urandom,
                ei, r >= TO, (r < TO) && is_ill(w));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
